seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexing scan controller for the 4-digit common-anode 7-seg driver.
//  Holds a 4-digit BCD value plus decimal points and drives the driver's showDigit/showNum
//  inputs, stepping digits 1..4 round-robin with a blanked dead time between digits.
//  New values load by valid/ready handshake and apply only at frame boundaries (no tearing).
// PARAMETERS
//  SCAN_DIV  16384  clk cycles per digit slot (>= DEAD_CYC+2)
//  DEAD_CYC  64     blanked cycles at start of each slot (anti-ghosting)
//  BLINK_DIV 64     frames per blink half-period (used only with SEG_SCAN_BLINK_EN)
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  rst         in   1   asynchronous reset, active-high
//  en          in   1   scan enable; low = hold current slot, output blanked
//  load_valid  in   1   new display value offered
//  load_ready  out  1   controller can accept a value
//  load_bcd    in   16  digit4..digit1 BCD, [15:12]=digit4, [3:0]=digit1
//  load_dp     in   4   decimal point per digit, bit i = digit i+1
//  blink_mask  in   4   per-digit blink select (ignored without SEG_SCAN_BLINK_EN)
//  showDigit   out  4   digit select to driver, values 1..4 only
//  showNum     out  6   {dp, 1'b0, bcd[3:0]}; 6'd0 = blank code
//  frame_done  out  1   1-cycle pulse when slot 4 ends
// BEHAVIOUR
//  Reset (async, all outputs registered): showDigit=1, showNum=0, load_ready=1,
//   frame_done=0, display regs (bcd/dp)=0, shadow empty, slot counter=0, state=S_DEAD.
//  Slot counter cnt counts 0..SCAN_DIV-1 when en=1; wraps to 0 and advances digit
//   1->2->3->4->1. When en=0: cnt, digit, state frozen; showNum forced 0.
//  FSM per slot: S_DEAD (cnt<DEAD_CYC): showNum=0; S_SHOW (cnt>=DEAD_CYC):
//   showNum={dp[d-1],1'b0,bcd[d]}. S_SHOW->S_DEAD on cnt wrap.
//  Outputs registered: showDigit/showNum change 1 cycle after the cnt value causing them.
//  Digit change occurs only while showNum already blank (dead time covers transition).
//  Handshake: transfer when load_valid&&load_ready at posedge; data into shadow,
//   load_ready drops next cycle. Shadow copied to display regs on cycle of digit-4 wrap
//   (same edge frame_done pulses); load_ready rises the following cycle.
//  Transfer on the same edge as the digit-4 wrap: shadow written; applied at NEXT frame.
//  BCD digit >9 passed through unchanged (driver shows 8. pattern); no saturation.
//  en=0 blocks frame boundaries, so a pending shadow stays pending; load_ready stays 0.
//  frame_done asserted only when en=1 and digit 4 wraps.
//  Reset mid-frame: everything returns to reset values immediately; pending shadow lost.
// CONFIGURATION
//  SEG_SCAN_BLINK_EN defined: frame counter (BLINK_DIV) toggles blink phase at each
//   BLINK_DIV-th frame_done; in off phase, digits with blink_mask bit set show
//   showNum=0 during S_SHOW. Phase=on after reset.
//  SEG_SCAN_BLINK_EN undefined: no blink logic; blink_mask unused; digits always shown.
// TESTING (bench uses SCAN_DIV=16, DEAD_CYC=2, BLINK_DIV=2)
//  Reset release, no load -> showDigit cycles 1,2,3,4,1 every 16 clks; showNum=0 always.
//  Load bcd=16'h1234, dp=4'b0001 mid-frame -> load_ready=0 until frame end; next frame
//   digit1 shows 6'h24 (dp+4), digit2 6'h03, digit3 6'h02, digit4 6'h01 from cnt=2.
//  Each slot: showNum=0 for first 2 clks after showDigit changes, then value for 14.
//  en=0 for 40 clks mid-slot 3 -> showDigit stays 3, showNum=0, no frame_done; resumes.
//  Assert rst during slot 2 with pending load -> showDigit=1, showNum=0, load_ready=1 at once.
//  SEG_SCAN_BLINK_EN, blink_mask=4'b1000, bcd=16'h9000 -> digit4 shows 6'h09 for 2 frames,
//   6'h00 for 2 frames, repeating; digits 1-3 unaffected.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-seg time-multiplexed scan controller.
// Ports: clk, rst (async, active-high), en; load_valid/load_ready/load_bcd/load_dp
// load handshake; blink_mask; showDigit (1..4), showNum {dp,0,bcd}; frame_done.
// Option: define SEG_SCAN_BLINK_EN to enable per-digit blinking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 16384,
  parameter int DEAD_CYC  = 64,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_bcd,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  showDigit,
  output logic [5:0]  showNum,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYC);

  typedef enum logic {S_DEAD, S_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          slot_end;
  logic          fwrap;
  logic          xfer;
  logic          blank;
  logic [5:0]    num_d;

  logic [15:0] bcd_q, sh_bcd;
  logic [3:0]  dp_q, sh_dp;
  logic        sh_full;

  assign slot_end = en && (cnt_q == CNT_MAX);
  assign fwrap    = slot_end && (dig_q == 2'd3);
  assign xfer     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        dig_d = dig_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    unique case (state_q)
      S_DEAD: if (en && (cnt_d >= DEAD)) state_d = S_SHOW;
      S_SHOW: if (slot_end && (DEAD != '0)) state_d = S_DEAD;
      default: state_d = S_DEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DEAD;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  // Shadow holds one offered value until the frame boundary so a
  // frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q      <= '0;
      dp_q       <= '0;
      sh_bcd     <= '0;
      sh_dp      <= '0;
      sh_full    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      if (fwrap && sh_full) begin
        bcd_q   <= sh_bcd;
        dp_q    <= sh_dp;
        sh_full <= 1'b0;
      end
      if (xfer) begin
        sh_bcd  <= load_bcd;
        sh_dp   <= load_dp;
        sh_full <= 1'b1;
      end
      // Ready returns one cycle after the shadow drains.
      load_ready <= !xfer && !sh_full;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_DIV - 1);

  logic [FW-1:0] fcnt_q;
  logic          phase_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q   <= '0;
      phase_on <= 1'b1;
    end else if (fwrap) begin
      if (fcnt_q == FRM_MAX) begin
        fcnt_q   <= '0;
        phase_on <= !phase_on;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign blank = !phase_on && blink_mask[dig_q];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, (BLINK_DIV != 0)};
  assign blank = 1'b0;
`endif

  always_comb begin
    num_d = 6'd0;
    if (en && (state_q == S_SHOW) && !blank)
      num_d = {dp_q[dig_q], 1'b0, bcd_q[{dig_q, 2'b00} +: 4]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      showDigit  <= 4'd1;
      showNum    <= 6'd0;
      frame_done <= 1'b0;
    end else begin
      showDigit  <= {2'b00, dig_q} + 4'd1;
      showNum    <= num_d;
      frame_done <= fwrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized bench for seg_scan_ctrl against a
// position-in-frame reference model.
module tb_seg_scan_ctrl;

  localparam int SD = 16;
  localparam int DC = 2;
  localparam int BD = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_bcd = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  showDigit;
  logic [5:0]  showNum;
  logic        frame_done;

  seg_scan_ctrl #(
    .SCAN_DIV (SD),
    .DEAD_CYC (DC),
    .BLINK_DIV(BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_bcd  (load_bcd),
    .load_dp   (load_dp),
    .blink_mask(blink_mask),
    .showDigit (showDigit),
    .showNum   (showNum),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pos = enabled cycles into the current frame.
  int          pos;
  logic [15:0] m_bcd, p_bcd;
  logic [3:0]  m_dp, p_dp;
  bit          pend;
  bit          m_rdy;
  int          frames;
  bit          blink_off;
  logic [3:0]  e_dig;
  logic [5:0]  e_num;
  bit          e_fd;

  task automatic m_reset();
    pos = 0;
    m_bcd = '0;
    m_dp = '0;
    p_bcd = '0;
    p_dp = '0;
    pend = 0;
    m_rdy = 1;
    frames = 0;
    blink_off = 0;
    e_dig = 4'd1;
    e_num = 6'd0;
    e_fd = 0;
  endtask

  task automatic check_outs(input string pfx);
    chk({pfx, "_digit"}, 16'(showDigit), 16'(e_dig));
    chk({pfx, "_num"}, 16'(showNum), 16'(e_num));
    chk({pfx, "_ready"}, 16'(load_ready), 16'(m_rdy));
    chk({pfx, "_fdone"}, 16'(frame_done), 16'(e_fd));
  endtask

  // Called at a negedge: drive, clock once, predict, check, return at negedge.
  task automatic step(input bit e, input bit v, input logic [15:0] b,
                      input logic [3:0] d);
    int   slot, off;
    bit   show, wrap, take, was_pend;
    logic [3:0] nib;
    en = e;
    load_valid = v;
    load_bcd = b;
    load_dp = d;
    @(posedge clk);
    slot = pos / SD;
    off = pos % SD;
    show = e && (off >= DC);
`ifdef SEG_SCAN_BLINK_EN
    if (blink_off && blink_mask[slot]) show = 0;
`endif
    nib = 4'((m_bcd >> (4 * slot)) & 16'hf);
    e_dig = 4'(slot + 1);
    e_num = show ? {m_dp[slot], 1'b0, nib} : 6'd0;
    wrap = e && (pos == FR - 1);
    e_fd = wrap;
    take = v && m_rdy;
    was_pend = pend;
    if (wrap) begin
      if (pend) begin
        m_bcd = p_bcd;
        m_dp = p_dp;
        pend = 0;
      end
      frames++;
      if (frames % BD == 0) blink_off = !blink_off;
    end
    if (take) begin
      p_bcd = b;
      p_dp = d;
      pend = 1;
    end
    m_rdy = !take && !was_pend;
    if (e) pos = (pos + 1) % FR;
    #1;
    check_outs("run");
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #2;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle scan: digits cycle, display blank
    repeat (80) step(1, 0, '0, '0);

    // Mid-frame load, observed over the next frames
    step(1, 1, 16'h1234, 4'b0001);
    repeat (150) step(1, 0, '0, '0);

    // Park in slot 3, offer a value, then freeze for 40 clocks
    for (int i = 0; i < FR && !(pos == 2 * SD + 6); i++)
      step(1, 0, '0, '0);
    step(1, 1, 16'h5A9F, 4'b1010);
    repeat (40) step(0, 0, '0, '0);
    repeat (100) step(1, 0, '0, '0);

    // Reset during slot 2 with a pending load
    for (int i = 0; i < FR && !(pos == SD + 3); i++)
      step(1, 0, '0, '0);
    step(1, 1, 16'h8765, 4'b1111);
    repeat (3) step(1, 0, '0, '0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_outs("midrst");
    @(negedge clk);
    en = 1'b0;
    load_valid = 1'b0;
    rst = 1'b0;
    repeat (70) step(1, 0, '0, '0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ((i % 97) == 0) blink_mask = 4'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           16'($urandom), 4'($urandom));
    end

    // Blink on digit 4 only
    blink_mask = 4'b1000;
    for (int i = 0; i < 2 * FR && !m_rdy; i++)
      step(1, 0, '0, '0);
    step(1, 1, 16'h9000, 4'b0000);
    repeat (FR * 7) step(1, 0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
